// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: arbitrates the shared parking lane between inbound and outbound cars and tracks occupancy
// Ports: clk, reset (async active-low); req_in/req_out car-waiting levels; enter/exit one-cycle passage pulses;
// gate_open/dir_in lane grant (dir_in=1 inbound); count/full/empty occupancy; timeout/seq_err one-cycle event pulses.
module parking_gate_ctrl #(
  parameter int CAPACITY = 16,
  parameter int CNT_W    = 5,
  parameter int TIMEOUT  = 100,
  parameter int TO_W     = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_in,
  input  logic             req_out,
  input  logic             enter,
  input  logic             exit,
  output logic             gate_open,
  output logic             dir_in,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             timeout,
  output logic             seq_err
);
  typedef enum logic [1:0] {IDLE, GRANT_IN, GRANT_OUT, CLEAR} state_t;
  state_t           state_q, state_d;
  logic             last_in_q, last_in_d;
  logic             gate_open_q, gate_open_d;
  logic             dir_in_q, dir_in_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic             timeout_q, timeout_d;
  logic             seq_err_q, seq_err_d;
  logic             elig_in, elig_out, match, stray;
  assign full      = count_q == CNT_W'(CAPACITY);
  assign empty     = count_q == '0;
  assign gate_open = gate_open_q;
  assign dir_in    = dir_in_q;
  assign count     = count_q;
  assign timeout   = timeout_q;
  assign seq_err   = seq_err_q;
  always_comb begin
    state_d   = state_q;
    last_in_d = last_in_q;
    count_d   = count_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    elig_in   = req_in & ~full;
    elig_out  = req_out & ~empty;
    match     = (state_q == GRANT_IN) ? enter : (state_q == GRANT_OUT) ? exit : 1'b0;
    // any pulse that is not the one the current grant expects is a sequencing error
    stray     = (state_q == GRANT_IN) ? exit : (state_q == GRANT_OUT) ? enter : (enter | exit);
    seq_err_d = stray;
    case (state_q)
      IDLE: if (elig_in | elig_out) begin
        // on a tie, alternate away from the previous grant
        state_d   = (elig_in & (~elig_out | ~last_in_q)) ? GRANT_IN : GRANT_OUT;
        last_in_d = state_d == GRANT_IN;
        timer_d   = '0;
      end
      GRANT_IN, GRANT_OUT: begin
        timer_d = timer_q + 1'b1;
        if (match) begin
          state_d = CLEAR;
          count_d = (state_q == GRANT_IN) ? (full ? count_q : count_q + 1'b1)
                                          : (empty ? count_q : count_q - 1'b1);
        end else if (timer_q == TO_W'(TIMEOUT - 1)) begin
          state_d   = CLEAR;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    gate_open_d = (state_d == GRANT_IN) | (state_d == GRANT_OUT);
    dir_in_d    = (state_d == GRANT_IN) ? 1'b1 : (state_d == GRANT_OUT) ? 1'b0 : dir_in_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_in_q   <= 1'b0;
      gate_open_q <= 1'b0;
      dir_in_q    <= 1'b0;
      count_q     <= '0;
      timer_q     <= '0;
      timeout_q   <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_in_q   <= last_in_d;
      gate_open_q <= gate_open_d;
      dir_in_q    <= dir_in_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      timeout_q   <= timeout_d;
      seq_err_q   <= seq_err_d;
    end
  end
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed stimulus with a per-cycle lane/occupancy model and literal spot checks
module tb_parking_gate_ctrl;
  localparam int CAP = 16;
  localparam int TMO = 100;
  logic       clk = 0, reset = 0, req_in = 0, req_out = 0, enter = 0, exit = 0;
  logic       gate_open, dir_in, full, empty, timeout, seq_err;
  logic [4:0] count;
  int         errors = 0, checks = 0;
  bit         m_open, m_dir, m_clear, m_last_in, m_to, m_se, m_match, m_other, m_ei, m_eo;
  int         m_cnt, m_age;
  bit         d;
  bit         exp_dir [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int         exp_cnt [4] = '{4, 3, 4, 3};

  parking_gate_ctrl dut (
    .clk(clk), .reset(reset), .req_in(req_in), .req_out(req_out), .enter(enter), .exit(exit),
    .gate_open(gate_open), .dir_in(dir_in), .count(count), .full(full), .empty(empty),
    .timeout(timeout), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // lane model: a grant is open or not, for how many cycles, and a one-cycle cool-down after closing
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_open = 0; m_dir = 0; m_clear = 0; m_last_in = 0; m_to = 0; m_se = 0; m_cnt = 0; m_age = 0;
    end else begin
      m_to = 0;
      if (m_open) begin
        m_match = m_dir ? enter : exit;
        m_other = m_dir ? exit : enter;
        m_se = m_other;
        if (m_match) begin
          m_cnt = m_dir ? ((m_cnt < CAP) ? m_cnt + 1 : m_cnt) : ((m_cnt > 0) ? m_cnt - 1 : 0);
          m_open = 0; m_clear = 1;
        end else if (m_age == TMO - 1) begin
          m_to = 1; m_open = 0; m_clear = 1;
        end else m_age++;
      end else begin
        m_se = enter | exit;
        if (m_clear) m_clear = 0;
        else begin
          m_ei = req_in && (m_cnt < CAP);
          m_eo = req_out && (m_cnt > 0);
          if (m_ei || m_eo) begin
            m_dir = m_ei && (!m_eo || !m_last_in);
            m_last_in = m_dir;
            m_open = 1;
            m_age = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) if (reset) begin
    chk("m_gate_open", int'(gate_open), int'(m_open));
    if (m_open) chk("m_dir_in", int'(dir_in), int'(m_dir));
    chk("m_count", int'(count), m_cnt);
    chk("m_full", int'(full), int'(m_cnt == CAP));
    chk("m_empty", int'(empty), int'(m_cnt == 0));
    chk("m_timeout", int'(timeout), int'(m_to));
    chk("m_seq_err", int'(seq_err), int'(m_se));
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_open();
    int n = 0;
    while (!gate_open && n < 20) begin tick(1); n++; end
    chk("grant_wait", int'(gate_open), 1);
  endtask

  task automatic serve(output bit dd);
    wait_open();
    dd = dir_in;
    if (dir_in) enter = 1; else exit = 1;
    tick(1);
    enter = 0; exit = 0;
  endtask

  initial begin
    #12;
    chk("rst_gate_open", int'(gate_open), 0);
    chk("rst_dir_in", int'(dir_in), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_seq_err", int'(seq_err), 0);
    @(posedge clk); #1; reset = 1;
    tick(1);
    req_in = 1; tick(1);
    chk("first_grant_open", int'(gate_open), 1);
    chk("first_grant_dir", int'(dir_in), 1);
    enter = 1; tick(1); enter = 0;
    chk("enter_count", int'(count), 1);
    chk("enter_close", int'(gate_open), 0);
    tick(1);
    chk("clear_closed", int'(gate_open), 0);
    tick(1);
    chk("reopen", int'(gate_open), 1);
    req_in = 0; enter = 1; tick(1); enter = 0;
    chk("count_2", int'(count), 2);
    tick(1);
    req_in = 1;
    repeat (2) serve(d);
    chk("count_4", int'(count), 4);
    req_in = 0; req_out = 1;
    serve(d);
    chk("out_dir", int'(d), 0);
    chk("count_3", int'(count), 3);
    req_in = 1;
    for (int i = 0; i < 4; i++) begin
      serve(d);
      chk("rr_dir", int'(d), int'(exp_dir[i]));
      chk("rr_count", int'(count), exp_cnt[i]);
    end
    req_out = 0;
    repeat (13) serve(d);
    chk("fill_count", int'(count), 16);
    chk("fill_full", int'(full), 1);
    tick(5);
    chk("full_no_grant", int'(gate_open), 0);
    req_out = 1;
    serve(d);
    chk("full_out_dir", int'(d), 0);
    chk("full_out_count", int'(count), 15);
    chk("full_cleared", int'(full), 0);
    req_in = 0; req_out = 0;
    tick(2);
    reset = 0; tick(1); reset = 1;
    chk("empty_after_rst", int'(empty), 1);
    req_out = 1; tick(5);
    chk("empty_no_grant", int'(gate_open), 0);
    enter = 1; tick(1); enter = 0;
    chk("idle_seq_err", int'(seq_err), 1);
    chk("idle_count", int'(count), 0);
    tick(1);
    chk("seq_err_one_cycle", int'(seq_err), 0);
    req_out = 0;
    req_in = 1; wait_open(); req_in = 0;
    tick(99);
    chk("pre_timeout_open", int'(gate_open), 1);
    chk("pre_timeout_pulse", int'(timeout), 0);
    tick(1);
    chk("timeout_close", int'(gate_open), 0);
    chk("timeout_pulse", int'(timeout), 1);
    chk("timeout_count", int'(count), 0);
    tick(1);
    chk("timeout_one_cycle", int'(timeout), 0);
    tick(1);
    req_in = 1; wait_open(); req_in = 0;
    tick(99);
    enter = 1; tick(1); enter = 0;
    chk("late_enter_count", int'(count), 1);
    chk("late_enter_no_timeout", int'(timeout), 0);
    chk("late_enter_close", int'(gate_open), 0);
    tick(2);
    req_in = 1; wait_open(); req_in = 0;
    enter = 1; exit = 1; tick(1); enter = 0; exit = 0;
    chk("both_count", int'(count), 2);
    chk("both_seq_err", int'(seq_err), 1);
    tick(2);
    req_in = 1; wait_open(); req_in = 0;
    #2 reset = 0; #1;
    chk("async_rst_gate", int'(gate_open), 0);
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_empty", int'(empty), 1);
    tick(1); reset = 1;
    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Controller for the single shared entry/exit lane of the parking lot.
- Takes "car waiting" requests from both sides and grants the lane to one direction at a time.
- Consumes the one-cycle enter/exit passage pulses from the sensor FSM, keeps the occupancy count, blocks entry when the lot is full and exit when it is empty.
- Recovers from abandoned grants with a timeout.

Parameters:
- CAPACITY, 16: number of spaces; count saturates at this value.
- CNT_W, 5: width of count; must satisfy 2^CNT_W > CAPACITY.
- TIMEOUT, 100: clock cycles a grant stays open without a matching passage pulse.
- TO_W, 7: timer width; must satisfy 2^TO_W >= TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_in  input  1  level; car waiting outside to enter.
- req_out  input  1  level; car waiting inside to leave.
- enter  input  1  one-cycle pulse from sensor FSM; car completed entry.
- exit  input  1  one-cycle pulse from sensor FSM; car completed exit.
- gate_open  output  1  registered; lane barrier raised.
- dir_in  output  1  registered; 1 = lane granted inbound, 0 = outbound. Valid only while gate_open=1.
- count  output  CNT_W  registered occupancy.
- full  output  1  count == CAPACITY.
- empty  output  1  count == 0.
- timeout  output  1  one-cycle pulse; grant closed without passage.
- seq_err  output  1  one-cycle pulse; passage pulse not matching the current grant.

Behaviour:
- Reset (reset=0, asynchronous) forces these values:
  - state=IDLE, gate_open=0, dir_in=0, count=0, timeout=0, seq_err=0, timer=0.
  - last_grant=OUT, so the first tie goes inbound.
- States: IDLE, GRANT_IN, GRANT_OUT, CLEAR.
- Eligibility in IDLE:
  - elig_in = req_in & ~full
  - elig_out = req_out & ~empty
- IDLE transitions:
  - Only elig_in: go to GRANT_IN.
  - Only elig_out: go to GRANT_OUT.
  - Both: grant the direction opposite last_grant (round-robin). Update last_grant on every grant.
  - Neither: stay in IDLE.
- Request latency: a request sampled at edge N in IDLE gives gate_open=1 and the correct dir_in from cycle N+1. Timer clears to 0 on grant entry.
- GRANT_IN:
  - gate_open=1, dir_in=1.
  - enter=1: count+1 (saturating at CAPACITY), go to CLEAR.
  - exit=1: seq_err pulse, count unchanged, remain.
- GRANT_OUT:
  - Mirror of GRANT_IN.
  - exit=1: count-1 (saturating at 0), go to CLEAR.
  - enter=1: seq_err pulse, count unchanged, remain.
- Timer, in both GRANT states:
  - Increments every cycle in the state.
  - If timer==TIMEOUT-1 with no matching pulse: timeout pulse next cycle, go to CLEAR, count unchanged.
  - A matching pulse in the same cycle as expiry wins: count updates, no timeout.
- Simultaneous enter and exit in a GRANT state: the matching pulse is taken and the other raises seq_err, in the same cycle.
- CLEAR:
  - gate_open=0 for exactly one cycle, then IDLE.
  - Passage pulses here: seq_err, count unchanged.
- Any enter/exit pulse in IDLE: seq_err, count unchanged.
- Cycle-level timing:
  - A passage pulse at cycle M gives updated count and gate_open=0 at M+1.
  - IDLE at M+2.
  - Earliest next gate_open at M+3.
- Requests dropping during a grant do not close the gate; only a passage pulse or timeout closes it.
- full and empty are decoded from the count register, so they are glitch-free.
- Reset mid-grant closes the gate immediately and clears count.

Test Plan:
- Reset, then req_in=1 held → gate_open=1, dir_in=1 one cycle later. enter pulse → count=1, gate_open=0 next cycle. Gate reopens inbound 3 cycles after the pulse.
- req_in=req_out=1 from reset with count=3 → grants alternate IN, OUT, IN, OUT on successive passages. count sequence 4,3,4,3.
- Fill to CAPACITY=16 → full=1. req_in alone → no grant, gate_open stays 0. req_out → GRANT_OUT; exit → count=15, full=0.
- count=0, req_out=1 → no grant (empty=1). enter pulse in IDLE → seq_err=1 for one cycle, count stays 0.
- GRANT_IN with no pulse for TIMEOUT=100 cycles → timeout pulse once, gate_open=0, count unchanged. Repeat with enter arriving on cycle 99 → count+1, no timeout.
- GRANT_IN, then enter and exit in the same cycle → count+1, seq_err=1. Assert reset=0 during a later grant → gate_open=0 and count=0 immediately, without waiting for a clock edge.
